ram_mult_sequencer: RTL and testbench

- Controller that sequences the 8x8 single-port synchronous RAM to perform an unsigned multiply.
- Reads operand A and operand B from RAM, then computes A*B with an iterative shift-add (one bit per cycle).
- Writes the 2*DATA_W-bit product back to RAM as high byte then low byte.
- Sits between the top-level FSM/user interface and the RAM; it is the RAM's only master while busy.

---
 rtl/ram_mult_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ram_mult_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_mult_sequencer.sv
// Sequences a single-port synchronous RAM through an unsigned multiply:
// fetch A and B, shift-add one bit per cycle, write the product back high byte first.
module ram_mult_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADR_W-1:0]      adr_a,
  input  logic [ADR_W-1:0]      adr_b,
  input  logic [ADR_W-1:0]      adr_p,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product,
  output logic                  ram_w,
  output logic [ADR_W-1:0]      ram_adr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int P_W   = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    LD_B  = 3'd3,
    MUL   = 3'd4,
    WR_HI = 3'd5,
    WR_LO = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [ADR_W-1:0]   adr_a_r;
  logic [ADR_W-1:0]   adr_b_r;
  logic [ADR_W-1:0]   adr_p_r;
  logic [ADR_W-1:0]   adr_lo_s;
  logic [DATA_W-1:0]  reg_a_r;
  logic [DATA_W-1:0]  reg_b_r;
  logic [P_W-1:0]     acc_r;
  logic [P_W-1:0]     acc_s;
  logic [P_W-1:0]     partial_s;
  logic [P_W-1:0]     product_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_s;

  assign last_s   = (cnt_r == CNT_W'(DATA_W - 1));
  // Low byte lands one word above the high byte, wrapping at the top of the RAM.
  assign adr_lo_s = adr_p_r + {{(ADR_W-1){1'b0}}, 1'b1};
  assign product  = product_r;

  // Next state and the shift-add step for the current multiplier bit.
  always_comb begin
    state_s   = state_r;
    partial_s = {P_W{1'b0}};
    if (reg_b_r[cnt_r]) begin
      partial_s = {{DATA_W{1'b0}}, reg_a_r} << cnt_r;
    end else begin
      partial_s = {P_W{1'b0}};
    end
    acc_s = acc_r + partial_s;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RD_A;
        end else begin
          state_s = IDLE;
        end
      end
      RD_A:  state_s = RD_B;
      RD_B:  state_s = LD_B;
      LD_B:  state_s = MUL;
      MUL: begin
        if (last_s) begin
          state_s = WR_HI;
        end else begin
          state_s = MUL;
        end
      end
      WR_HI: state_s = WR_LO;
      WR_LO: state_s = DONE;
      DONE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured addresses, operands, accumulator and product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      adr_a_r   <= {ADR_W{1'b0}};
      adr_b_r   <= {ADR_W{1'b0}};
      adr_p_r   <= {ADR_W{1'b0}};
      reg_a_r   <= {DATA_W{1'b0}};
      reg_b_r   <= {DATA_W{1'b0}};
      acc_r     <= {P_W{1'b0}};
      product_r <= {P_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            adr_a_r <= adr_a;
            adr_b_r <= adr_b;
            adr_p_r <= adr_p;
          end
        end
        // ram_dout carries the word addressed in the previous cycle.
        RD_B: reg_a_r <= ram_dout;
        LD_B: begin
          reg_b_r <= ram_dout;
          acc_r   <= {P_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
        MUL: begin
          acc_r <= acc_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_s) begin
            product_r <= acc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM strobes and status decoded from the state register.
  always_comb begin
    ram_w   = 1'b0;
    ram_adr = {ADR_W{1'b0}};
    ram_din = {DATA_W{1'b0}};
    busy    = 1'b1;
    done    = 1'b0;
    case (state_r)
      IDLE:  busy = 1'b0;
      RD_A:  ram_adr = adr_a_r;
      RD_B:  ram_adr = adr_b_r;
      LD_B:  ram_adr = adr_b_r;
      MUL:   ram_adr = {ADR_W{1'b0}};
      WR_HI: begin
        ram_w   = 1'b1;
        ram_adr = adr_p_r;
        ram_din = product_r[P_W-1:DATA_W];
      end
      WR_LO: begin
        ram_w   = 1'b1;
        ram_adr = adr_lo_s;
        ram_din = product_r[DATA_W-1:0];
      end
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ram_mult_sequencer.sv
// Directed bench for ram_mult_sequencer with a behavioural 8x8 synchronous RAM.
module tb_ram_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  adr_a, adr_b, adr_p;
  logic        busy, done;
  logic [15:0] product;
  logic        ram_w;
  logic [2:0]  ram_adr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [7:0]  mem [0:7];

  int n_chk  = 0;
  int n_fail = 0;

  ram_mult_sequencer #(.DATA_W(8), .ADR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .adr_a(adr_a), .adr_b(adr_b), .adr_p(adr_p),
    .busy(busy), .done(done), .product(product),
    .ram_w(ram_w), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w) mem[ram_adr] <= ram_din;
    ram_dout <= mem[ram_adr];
  end

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  p;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one op at the next edge and watches ncyc cycles; optionally re-pulses start.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] p,
                        input int repulse_at, input int ncyc,
                        output int first_done, output int done_cnt,
                        output int wr_cnt, output int busy_low);
    first_done = -1; done_cnt = 0; wr_cnt = 0; busy_low = 0;
    adr_a = a; adr_b = b; adr_p = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (ram_w) wr_cnt++;
      if (!busy && k <= 14) busy_low++;
      start = (k == repulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  int fd, dc, wc, bl;
  int done_at [$];
  logic [2:0] plo;

  initial begin
    vecs[0] = '{va: 8'd13,  vb: 8'd11,  a: 3'd1, b: 3'd2, p: 3'd3, exp: 16'h008F};
    vecs[1] = '{va: 8'd255, vb: 8'd255, a: 3'd5, b: 3'd6, p: 3'd0, exp: 16'hFE01};
    vecs[2] = '{va: 8'd9,   vb: 8'd9,   a: 3'd2, b: 3'd2, p: 3'd7, exp: 16'h0051};
    vecs[3] = '{va: 8'd6,   vb: 8'd7,   a: 3'd3, b: 3'd4, p: 3'd3, exp: 16'h002A};
    vecs[4] = '{va: 8'd0,   vb: 8'd200, a: 3'd5, b: 3'd6, p: 3'd1, exp: 16'h0000};
    vecs[5] = '{va: 8'd128, vb: 8'd3,   a: 3'd0, b: 3'd7, p: 3'd5, exp: 16'h0180};

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst = 1'b1; start = 1'b0; adr_a = 3'd0; adr_b = 3'd0; adr_p = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_ram_w", {31'd0, ram_w}, 32'd0);
    chk("reset_ram_adr", {29'd0, ram_adr}, 32'd0);
    chk("reset_ram_din", {24'd0, ram_din}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      plo = vecs[i].p + 3'd1;
      mem[vecs[i].p] = 8'hEE;
      mem[plo] = 8'hEE;
      mem[vecs[i].a] = vecs[i].va;
      mem[vecs[i].b] = vecs[i].vb;
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, -1, 16, fd, dc, wc, bl);
      chk($sformatf("v%0d_done_cycle", i), fd, 32'd14);
      chk($sformatf("v%0d_done_count", i), dc, 32'd1);
      chk($sformatf("v%0d_write_cycles", i), wc, 32'd2);
      chk($sformatf("v%0d_busy_gaps", i), bl, 32'd0);
      chk($sformatf("v%0d_product", i), {16'd0, product}, {16'd0, vecs[i].exp});
      chk($sformatf("v%0d_mem_hi", i), {24'd0, mem[vecs[i].p]}, {24'd0, vecs[i].exp[15:8]});
      chk($sformatf("v%0d_mem_lo", i), {24'd0, mem[plo]}, {24'd0, vecs[i].exp[7:0]});
    end

    repeat (5) @(posedge clk);
    #1;
    chk("product_held", {16'd0, product}, 32'h0000_0180);

    // A second start mid-operation must be dropped.
    mem[1] = 8'd13; mem[2] = 8'd11;
    run_op(3'd1, 3'd2, 3'd3, 5, 30, fd, dc, wc, bl);
    chk("repulse_done_cycle", fd, 32'd14);
    chk("repulse_done_count", dc, 32'd1);
    chk("repulse_write_cycles", wc, 32'd2);
    chk("repulse_busy_gaps", bl, 32'd0);

    // Start held high: back-to-back ops on a 15-cycle period.
    mem[1] = 8'd3; mem[2] = 8'd5;
    adr_a = 3'd1; adr_b = 3'd2; adr_p = 3'd6;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 31; k++) begin
      if (done) done_at.push_back(k);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("hold_done_count", done_at.size(), 32'd2);
    if (done_at.size() == 2) begin
      chk("hold_first_done", done_at[0], 32'd14);
      chk("hold_second_done", done_at[1], 32'd29);
    end
    chk("hold_product", {16'd0, product}, 32'd15);

    // Reset during MUL aborts with no writes.
    mem[1] = 8'd13; mem[2] = 8'd11; mem[3] = 8'h55; mem[4] = 8'h66;
    adr_a = 3'd1; adr_b = 3'd2; adr_p = 3'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wc = 0;
    for (int k = 1; k < 6; k++) begin
      if (ram_w) wc++;
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    chk("abort_ram_w", {31'd0, ram_w}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ram_w) wc++;
      @(posedge clk); #1;
    end
    chk("abort_write_cycles", wc, 32'd0);
    chk("abort_mem3", {24'd0, mem[3]}, 32'h55);
    chk("abort_mem4", {24'd0, mem[4]}, 32'h66);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
